// File: rtl/axi_addr_xbar.sv
// axi_addr_xbar: AW/AR address crossbar with per-slave round-robin and registered outputs.
// Define AXI_XBAR_DECERR_EN to answer decode misses locally with dec_err_o instead of the default slave.
module axi_addr_xbar #(
  parameter int NUM_MASTER = 2,
  parameter int NUM_SLAVE = 3,
  parameter int WIDTH_CID = 4,
  parameter int WIDTH_ID = 8,
  parameter int WIDTH_AD = 32,
  parameter int WIDTH_SID = WIDTH_CID + WIDTH_ID,
  parameter logic [NUM_SLAVE*WIDTH_AD-1:0] ADDR_BASE = {32'h4000, 32'h2000, 32'h0},
  parameter logic [NUM_SLAVE*8-1:0] ADDR_LENGTH = {8'd12, 8'd12, 8'd12},
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [NUM_MASTER-1:0] m_valid_i,
  output logic [NUM_MASTER-1:0] m_ready_o,
  input  logic [NUM_MASTER*WIDTH_AD-1:0] m_addr_i,
  input  logic [NUM_MASTER*WIDTH_ID-1:0] m_id_i,
  input  logic [NUM_MASTER*4-1:0] m_len_i,
  output logic [NUM_SLAVE-1:0] s_valid_o,
  input  logic [NUM_SLAVE-1:0] s_ready_i,
  output logic [NUM_SLAVE*WIDTH_AD-1:0] s_addr_o,
  output logic [NUM_SLAVE*WIDTH_SID-1:0] s_sid_o,
  output logic [NUM_SLAVE*4-1:0] s_len_o,
  input  logic [NUM_MASTER-1:0] rsp_done_i,
  output logic [NUM_MASTER-1:0] dec_err_o,
  output logic [NUM_MASTER*WIDTH_ID-1:0] dec_err_id_o
);
  localparam int MW = NUM_MASTER > 1 ? $clog2(NUM_MASTER) : 1;
  localparam int SW = NUM_SLAVE > 1 ? $clog2(NUM_SLAVE) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  logic [WIDTH_AD-1:0] addr [NUM_MASTER];
  logic [WIDTH_ID-1:0] id [NUM_MASTER];
  logic [3:0] len [NUM_MASTER];
  logic [SW-1:0] dtgt [NUM_MASTER];
  logic [SW-1:0] tgt [NUM_MASTER];
  logic [CW-1:0] cnt [NUM_MASTER];
  logic [MW-1:0] rr [NUM_SLAVE];
  logic [MW-1:0] gm [NUM_SLAVE];
  logic [NUM_SLAVE-1:0] gv;
  logic [NUM_MASTER-1:0] req, elig, grant;

  function automatic logic match(input logic [WIDTH_AD-1:0] a, input int s);
    return ((a ^ ADDR_BASE[s*WIDTH_AD +: WIDTH_AD]) >> ADDR_LENGTH[s*8 +: 8]) == '0;
  endfunction

  function automatic logic [MW-1:0] nxt(input logic [MW-1:0] r, input int i);
    int a;
    a = int'(r) + i;
    return MW'(a >= NUM_MASTER ? a - NUM_MASTER : a);
  endfunction

  // Descending scan so the lowest matching slave wins; a miss falls to the last slave.
  always_comb
    for (int m = 0; m < NUM_MASTER; m++) begin
      addr[m] = m_addr_i[m*WIDTH_AD +: WIDTH_AD];
      id[m] = m_id_i[m*WIDTH_ID +: WIDTH_ID];
      len[m] = m_len_i[m*4 +: 4];
      dtgt[m] = SW'(NUM_SLAVE - 1);
      for (int s = NUM_SLAVE - 1; s >= 0; s--)
        if (match(addr[m], s)) dtgt[m] = SW'(s);
    end

`ifdef AXI_XBAR_DECERR_EN
  logic [NUM_MASTER-1:0] miss;
  always_comb
    for (int m = 0; m < NUM_MASTER; m++) begin
      miss[m] = 1'b1;
      for (int s = 0; s < NUM_SLAVE; s++)
        if (match(addr[m], s)) miss[m] = 1'b0;
    end
  assign req = m_valid_i & ~miss;
  assign m_ready_o = grant | (m_valid_i & miss);
  always_ff @(posedge clk_i)
    if (rst_i) begin
      dec_err_o <= '0;
      dec_err_id_o <= '0;
    end else begin
      dec_err_o <= m_valid_i & miss;
      for (int m = 0; m < NUM_MASTER; m++)
        if (m_valid_i[m] && miss[m]) dec_err_id_o[m*WIDTH_ID +: WIDTH_ID] <= id[m];
    end
`else
  assign req = m_valid_i;
  assign m_ready_o = grant;
  assign dec_err_o = '0;
  assign dec_err_id_o = '0;
`endif

  // Same-target rule keeps responses of one master in order across slaves.
  always_comb
    for (int m = 0; m < NUM_MASTER; m++)
      elig[m] = req[m] && cnt[m] < CW'(MAX_OUTSTANDING) && (cnt[m] == '0 || tgt[m] == dtgt[m]);

  always_comb begin
    gv = '0;
    for (int s = 0; s < NUM_SLAVE; s++) begin
      gm[s] = '0;
      for (int i = 0; i < NUM_MASTER; i++)
        if (!gv[s] && (!s_valid_o[s] || s_ready_i[s]) && elig[nxt(rr[s], i)] && dtgt[nxt(rr[s], i)] == SW'(s)) begin
          gv[s] = 1'b1;
          gm[s] = nxt(rr[s], i);
        end
    end
  end

  always_comb
    for (int m = 0; m < NUM_MASTER; m++) begin
      grant[m] = 1'b0;
      for (int s = 0; s < NUM_SLAVE; s++)
        if (gv[s] && gm[s] == MW'(m)) grant[m] = 1'b1;
    end

  always_ff @(posedge clk_i)
    if (rst_i) begin
      s_valid_o <= '0;
      s_addr_o <= '0;
      s_sid_o <= '0;
      s_len_o <= '0;
      for (int s = 0; s < NUM_SLAVE; s++) rr[s] <= '0;
      for (int m = 0; m < NUM_MASTER; m++) begin
        cnt[m] <= '0;
        tgt[m] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SLAVE; s++)
        if (gv[s]) begin
          s_valid_o[s] <= 1'b1;
          s_addr_o[s*WIDTH_AD +: WIDTH_AD] <= addr[gm[s]];
          s_sid_o[s*WIDTH_SID +: WIDTH_SID] <= {WIDTH_CID'(gm[s]), id[gm[s]]};
          s_len_o[s*4 +: 4] <= len[gm[s]];
          rr[s] <= nxt(gm[s], 1);
        end else if (s_ready_i[s]) s_valid_o[s] <= 1'b0;
      for (int m = 0; m < NUM_MASTER; m++) begin
        if (grant[m]) tgt[m] <= dtgt[m];
        cnt[m] <= cnt[m] + CW'(grant[m]) - CW'(rsp_done_i[m] && cnt[m] != '0);
      end
    end
endmodule

// File: tb/tb_axi_addr_xbar.sv
// tb_axi_addr_xbar: directed vector table plus hand sequences for backpressure, limits, misses and reset.
module tb_axi_addr_xbar;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] m_valid = '0, m_ready, rsp_done = '0, dec_err;
  logic [63:0] m_addr = '0;
  logic [15:0] m_id = '0, dec_err_id;
  logic [7:0] m_len = {4'd7, 4'd3};
  logic [2:0] s_valid, s_ready = '0;
  logic [95:0] s_addr;
  logic [35:0] s_sid;
  logic [11:0] s_len;
  int total = 0, bad = 0;

  axi_addr_xbar dut (
    .clk_i(clk), .rst_i(rst), .m_valid_i(m_valid), .m_ready_o(m_ready), .m_addr_i(m_addr),
    .m_id_i(m_id), .m_len_i(m_len), .s_valid_o(s_valid), .s_ready_i(s_ready), .s_addr_o(s_addr),
    .s_sid_o(s_sid), .s_len_o(s_len), .rsp_done_i(rsp_done), .dec_err_o(dec_err), .dec_err_id_o(dec_err_id)
  );

  typedef struct {
    logic [1:0] v;
    logic [31:0] a0, a1;
    logic [7:0] i0, i1;
    logic [2:0] sr;
    logic [1:0] rd;
    logic [1:0] rdy;
    logic [2:0] sv;
    logic [35:0] sid;
  } vec_t;
  vec_t tab[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [7:0] i0, input logic [7:0] i1, input logic [2:0] sr, input logic [1:0] rd);
    @(negedge clk);
    m_valid = v;
    m_addr = {a1, a0};
    m_id = {i1, i0};
    s_ready = sr;
    rsp_done = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tab[0]  = '{2'b01, 32'h2010, 32'h0, 8'h5A, 8'h00, 3'b111, 2'b00, 2'b01, 3'b010, 36'h000_05A_000};
    tab[1]  = '{2'b00, 32'h0,    32'h0, 8'h00, 8'h00, 3'b111, 2'b01, 2'b00, 3'b000, 36'h0};
    tab[2]  = '{2'b11, 32'h0,    32'h0, 8'h11, 8'h22, 3'b111, 2'b00, 2'b01, 3'b001, 36'h000_000_011};
    tab[3]  = '{2'b11, 32'h0,    32'h0, 8'h11, 8'h22, 3'b111, 2'b00, 2'b10, 3'b001, 36'h000_000_122};
    tab[4]  = '{2'b11, 32'h0,    32'h0, 8'h11, 8'h22, 3'b111, 2'b00, 2'b01, 3'b001, 36'h000_000_011};
    tab[5]  = '{2'b11, 32'h0,    32'h0, 8'h11, 8'h22, 3'b111, 2'b11, 2'b10, 3'b001, 36'h000_000_122};
    tab[6]  = '{2'b00, 32'h0,    32'h0, 8'h00, 8'h00, 3'b111, 2'b11, 2'b00, 3'b000, 36'h0};
    tab[7]  = '{2'b01, 32'h0,    32'h0, 8'h01, 8'h00, 3'b111, 2'b00, 2'b01, 3'b001, 36'h000_000_001};
    tab[8]  = '{2'b01, 32'h2000, 32'h0, 8'h02, 8'h00, 3'b111, 2'b00, 2'b00, 3'b000, 36'h0};
    tab[9]  = '{2'b01, 32'h2000, 32'h0, 8'h02, 8'h00, 3'b111, 2'b01, 2'b00, 3'b000, 36'h0};
    tab[10] = '{2'b01, 32'h2000, 32'h0, 8'h02, 8'h00, 3'b111, 2'b00, 2'b01, 3'b010, 36'h000_002_000};
    tab[11] = '{2'b01, 32'h2000, 32'h0, 8'h03, 8'h00, 3'b111, 2'b01, 2'b01, 3'b010, 36'h000_003_000};
    tab[12] = '{2'b01, 32'h4000, 32'h0, 8'h04, 8'h00, 3'b111, 2'b00, 2'b00, 3'b000, 36'h0};
    tab[13] = '{2'b00, 32'h0,    32'h0, 8'h00, 8'h00, 3'b111, 2'b01, 2'b00, 3'b000, 36'h0};
    tab[14] = '{2'b01, 32'h4000, 32'h0, 8'h04, 8'h00, 3'b111, 2'b00, 2'b01, 3'b100, 36'h004_000_000};
    tab[15] = '{2'b00, 32'h0,    32'h0, 8'h00, 8'h00, 3'b111, 2'b01, 2'b00, 3'b000, 36'h0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_svalid", s_valid, 3'b000);
    chk("rst_sid", s_sid, 36'h0);
    chk("rst_decerr", dec_err, 2'b00);
    chk("rst_mready", m_ready, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      drive(tab[k].v, tab[k].a0, tab[k].a1, tab[k].i0, tab[k].i1, tab[k].sr, tab[k].rd);
      chk($sformatf("vec%0d_rdy", k), m_ready, tab[k].rdy);
      tick();
      chk($sformatf("vec%0d_sv", k), s_valid, tab[k].sv);
      for (int s = 0; s < 3; s++)
        if (tab[k].sv[s]) chk($sformatf("vec%0d_sid%0d", k, s), s_sid[s*12 +: 12], tab[k].sid[s*12 +: 12]);
    end
    // backpressure on slave 2
    drive(2'b01, 32'h4000, 32'h0, 8'h44, 8'h0, 3'b011, 2'b00);
    chk("bp_first_rdy", m_ready, 2'b01);
    tick();
    chk("bp_len", s_len[11:8], 4'd3);
    chk("bp_addr", s_addr[95:64], 32'h4000);
    for (int k = 0; k < 2; k++) begin
      drive(2'b01, 32'h4000, 32'h0, 8'h45, 8'h0, 3'b011, 2'b00);
      chk("bp_stall_rdy", m_ready, 2'b00);
      tick();
      chk("bp_hold_sv", s_valid, 3'b100);
      chk("bp_hold_sid", s_sid[35:24], 12'h044);
    end
    drive(2'b01, 32'h4000, 32'h0, 8'h45, 8'h0, 3'b111, 2'b00);
    chk("bp_drain_rdy", m_ready, 2'b01);
    tick();
    chk("bp_next_sid", s_sid[35:24], 12'h045);
    chk("bp_next_sv", s_valid, 3'b100);
    for (int k = 0; k < 2; k++) begin
      drive(2'b00, 32'h0, 32'h0, 8'h0, 8'h0, 3'b111, 2'b01);
      tick();
    end
    chk("bp_idle_sv", s_valid, 3'b000);
    // outstanding limit
    for (int k = 0; k < 8; k++) begin
      drive(2'b01, 32'h0, 32'h0, 8'(k), 8'h0, 3'b111, 2'b00);
      chk($sformatf("lim_acc%0d", k), m_ready, 2'b01);
      tick();
    end
    drive(2'b01, 32'h0, 32'h0, 8'h08, 8'h0, 3'b111, 2'b00);
    chk("lim_9th_stall", m_ready, 2'b00);
    tick();
    drive(2'b01, 32'h0, 32'h0, 8'h08, 8'h0, 3'b111, 2'b01);
    chk("lim_done_cycle", m_ready, 2'b00);
    tick();
    drive(2'b01, 32'h0, 32'h0, 8'h08, 8'h0, 3'b111, 2'b00);
    chk("lim_9th_acc", m_ready, 2'b01);
    tick();
    chk("lim_9th_sid", s_sid[11:0], 12'h008);
    for (int k = 0; k < 8; k++) begin
      drive(2'b00, 32'h0, 32'h0, 8'h0, 8'h0, 3'b111, 2'b01);
      tick();
    end
    // decode miss
    drive(2'b01, 32'h1000, 32'h0, 8'h33, 8'h0, 3'b111, 2'b00);
    chk("miss_rdy", m_ready, 2'b01);
    tick();
`ifdef AXI_XBAR_DECERR_EN
    chk("miss_decerr", dec_err, 2'b01);
    chk("miss_decerr_id", dec_err_id[7:0], 8'h33);
    chk("miss_sv", s_valid, 3'b000);
    drive(2'b00, 32'h0, 32'h0, 8'h0, 8'h0, 3'b111, 2'b00);
    tick();
    chk("miss_pulse_end", dec_err, 2'b00);
`else
    chk("miss_sv", s_valid, 3'b100);
    chk("miss_sid", s_sid[35:24], 12'h033);
    chk("miss_no_decerr", dec_err, 2'b00);
    drive(2'b00, 32'h0, 32'h0, 8'h0, 8'h0, 3'b111, 2'b01);
    tick();
`endif
    // reset mid-transfer
    drive(2'b11, 32'h0, 32'h2000, 8'h61, 8'h62, 3'b000, 2'b00);
    chk("mid_rdy", m_ready, 2'b11);
    tick();
    chk("mid_sv", s_valid, 3'b011);
    chk("mid_sid1", s_sid[23:12], 12'h162);
    drive(2'b00, 32'h0, 32'h0, 8'h0, 8'h0, 3'b000, 2'b00);
    rst = 1'b1;
    tick();
    chk("mid_rst_sv", s_valid, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b01, 32'h4000, 32'h0, 8'h70, 8'h0, 3'b111, 2'b00);
    chk("post_rst_rdy", m_ready, 2'b01);
    tick();
    chk("post_rst_sv", s_valid, 3'b100);
    chk("post_rst_sid", s_sid[35:24], 12'h070);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
